// File: rtl/trap_sched.sv
// trap_sched: machine-mode trap scheduler with a CLINT-style timer.
// Drains the pipe, presents one trap to csr, then flushes the front end.
module trap_sched #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [63:0] ex_pc,
    input  logic        ex_ecall,
    input  logic        ex_ebreak,
    input  logic        ex_mret,
    input  logic        pipe_empty,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        mie_msie,
    output logic        hold,
    output logic        flush,
    output logic        trap_fire,
    output logic [63:0] csr_vec,
    output logic [63:0] trap_pc,
    output logic        mtip,
    output logic        msip,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [63:0] bus_wdata,
    output logic [63:0] bus_rdata,
    output logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, DRAIN, FIRE, FLUSH} state_t;

    localparam logic [15:0] A_MSIP = 16'h0000;
    localparam logic [15:0] A_CMP  = 16'h4000;
    localparam logic [15:0] A_TIME = 16'hBFF8;
    localparam logic [7:0]  PMAX   = 8'(TICK_DIV - 1);

    localparam int C_MRET  = 0;
    localparam int C_EBRK  = 1;
    localparam int C_ECALL = 2;
    localparam int C_TIM   = 3;
    localparam int C_SW    = 4;

    state_t      state;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [7:0]  presc;
    logic [63:0] rd_mux;
    logic [4:0]  cause;
    logic [4:0]  cause_new;
    logic [63:0] pc_q;
    logic        wr;
    logic        rd;
    logic        int_ok;
    logic        exc_any;
    logic        fire_ok;
    logic [63:0] cause_vec;

    assign wr = bus_req & bus_we;
    assign rd = bus_req & ~bus_we;

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            A_MSIP:  rd_mux = {63'b0, msip};
            A_CMP:   rd_mux = mtimecmp;
            A_TIME:  rd_mux = mtime;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            presc     <= '0;
            msip      <= 1'b0;
            mtip      <= 1'b0;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= rd ? rd_mux : '0;
            mtip      <= (mtime >= mtimecmp);
            // A software write to mtime wins over the tick and restarts the prescaler
            if (wr && bus_addr == A_TIME) begin
                mtime <= bus_wdata;
                presc <= '0;
            end else if (presc == PMAX) begin
                mtime <= mtime + 64'd1;
                presc <= '0;
            end else begin
                presc <= presc + 8'd1;
            end
            if (wr && bus_addr == A_CMP) begin
                mtimecmp <= bus_wdata;
            end
            if (wr && bus_addr == A_MSIP) begin
                msip <= bus_wdata[0];
            end
        end
    end

    assign int_ok  = mstatus_mie & ((mie_mtie & mtip) | (mie_msie & msip));
    assign exc_any = ex_ecall | ex_ebreak | ex_mret;
    assign fire_ok = (cause[C_ECALL] | cause[C_EBRK] | cause[C_MRET]) | int_ok;

    assign cause_vec = {30'b0, cause[C_SW], cause[C_TIM],
                        29'b0, cause[C_ECALL], cause[C_EBRK], cause[C_MRET]};

    always_comb begin
        cause_new = '0;
        if (int_ok) begin
            if (mie_mtie && mtip) cause_new[C_TIM] = 1'b1;
            else                  cause_new[C_SW]  = 1'b1;
        end else if (ex_mret) begin
            cause_new[C_MRET] = 1'b1;
        end else if (ex_ecall) begin
            cause_new[C_ECALL] = 1'b1;
        end else if (ex_ebreak) begin
            cause_new[C_EBRK] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= 1'b0;
            flush     <= 1'b0;
            trap_fire <= 1'b0;
            csr_vec   <= '0;
            trap_pc   <= '0;
            cause     <= '0;
            pc_q      <= '0;
        end else begin
            flush     <= 1'b0;
            trap_fire <= 1'b0;
            csr_vec   <= '0;
            trap_pc   <= '0;
            unique case (state)
                IDLE: begin
                    if (ex_valid && (int_ok || exc_any)) begin
                        cause <= cause_new;
                        pc_q  <= ex_pc;
                        hold  <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Interrupts are re-qualified here; a withdrawn one fires nothing
                    if (pipe_empty) begin
                        state <= FIRE;
                        if (fire_ok) begin
                            trap_fire <= 1'b1;
                            csr_vec   <= cause_vec;
                            trap_pc   <= pc_q;
                        end
                    end
                end
                FIRE: begin
                    if (trap_fire) begin
                        flush <= 1'b1;
                        state <= FLUSH;
                    end else begin
                        hold  <= 1'b0;
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    hold  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    hold  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sched.sv
// tb_trap_sched: vector table, directed trap sequences and a
// randomized MMIO/timer run against an arithmetic model.
module tb_trap_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ecall, ex_ebreak, ex_mret;
    logic [63:0] ex_pc;
    logic        pipe_empty, mstatus_mie, mie_mtie, mie_msie;
    logic        hold, flush, trap_fire, mtip, msip, bus_ack;
    logic [63:0] csr_vec, trap_pc, bus_rdata;
    logic        bus_req, bus_we;
    logic [15:0] bus_addr;
    logic [63:0] bus_wdata;

    logic        b4_req, b4_we;
    logic [15:0] b4_addr;
    logic [63:0] b4_wdata;
    logic [63:0] b4_rdata, cv4, tp4;
    logic        b4_ack, h4, f4, tf4, mtip4, msip4;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [15:0] A_MSIP = 16'h0000;
    localparam logic [15:0] A_CMP  = 16'h4000;
    localparam logic [15:0] A_TIME = 16'hBFF8;
    localparam logic [63:0] V_TIM  = 64'h1_0000_0000;
    localparam logic [63:0] V_SW   = 64'h2_0000_0000;

    always #5 clk = ~clk;

    trap_sched dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_ecall(ex_ecall), .ex_ebreak(ex_ebreak), .ex_mret(ex_mret),
        .pipe_empty(pipe_empty),
        .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie), .mie_msie(mie_msie),
        .hold(hold), .flush(flush), .trap_fire(trap_fire),
        .csr_vec(csr_vec), .trap_pc(trap_pc),
        .mtip(mtip), .msip(msip),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    trap_sched #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst),
        .ex_valid(1'b0), .ex_pc(64'h0),
        .ex_ecall(1'b0), .ex_ebreak(1'b0), .ex_mret(1'b0),
        .pipe_empty(1'b1),
        .mstatus_mie(1'b0), .mie_mtie(1'b0), .mie_msie(1'b0),
        .hold(h4), .flush(f4), .trap_fire(tf4),
        .csr_vec(cv4), .trap_pc(tp4),
        .mtip(mtip4), .msip(msip4),
        .bus_req(b4_req), .bus_we(b4_we), .bus_addr(b4_addr),
        .bus_wdata(b4_wdata), .bus_rdata(b4_rdata), .bus_ack(b4_ack)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [63:0] d);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [63:0] d);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
        tick();
        bus_req = 1'b0;
        chk("rd_ack", {63'b0, bus_ack}, 64'd1);
        d = bus_rdata;
    endtask

    task automatic b4_write(input logic [15:0] a, input logic [63:0] d);
        b4_req = 1'b1; b4_we = 1'b1; b4_addr = a; b4_wdata = d;
        tick();
        b4_req = 1'b0; b4_we = 1'b0;
    endtask

    task automatic b4_read(input logic [15:0] a, output logic [63:0] d);
        b4_req = 1'b1; b4_we = 1'b0; b4_addr = a;
        tick();
        b4_req = 1'b0;
        d = b4_rdata;
    endtask

    // Present one instruction with pipe_empty=1 and walk the full sequence.
    task automatic run_trap(input string name, input logic [63:0] pc,
                            input logic fire, input logic [63:0] vec);
        ex_valid = 1'b1; ex_pc = pc; pipe_empty = 1'b1;
        tick();
        chk({name, "_hold"}, {63'b0, hold}, 64'd1);
        ex_valid = 1'b0; ex_ecall = 1'b0; ex_ebreak = 1'b0; ex_mret = 1'b0;
        tick();
        chk({name, "_fire"}, {63'b0, trap_fire}, {63'b0, fire});
        chk({name, "_vec"}, csr_vec, fire ? vec : 64'h0);
        chk({name, "_pc"}, trap_pc, fire ? pc : 64'h0);
        tick();
        chk({name, "_flush"}, {63'b0, flush}, {63'b0, fire});
        tick();
        chk({name, "_idle"}, {62'b0, hold, flush}, 64'd0);
    endtask

    typedef struct {
        string       name;
        logic        valid, ecall, ebreak, mret;
        logic [63:0] pc;
        logic        fire;
        logic [63:0] vec;
    } vec_t;

    vec_t vt[8];

    // Timer/MMIO reference: plain register values, one clock = one tick.
    logic [63:0] m_time, m_cmp;
    logic        m_msip, m_tip;

    function automatic logic [63:0] m_read(input logic [15:0] a);
        if (a == A_MSIP) return {63'b0, m_msip};
        if (a == A_CMP)  return m_cmp;
        if (a == A_TIME) return m_time;
        return 64'h0;
    endfunction

    initial begin
        logic [63:0] ra, rb;
        int cnt;

        vt[0] = '{"ecall",    1, 1, 0, 0, 64'h8000_0100, 1, 64'h4};
        vt[1] = '{"ebreak",   1, 0, 1, 0, 64'h8000_0104, 1, 64'h2};
        vt[2] = '{"mret",     1, 0, 0, 1, 64'h8000_0108, 1, 64'h1};
        vt[3] = '{"mret_ecl", 1, 1, 0, 1, 64'h8000_010C, 1, 64'h1};
        vt[4] = '{"ecl_ebrk", 1, 1, 1, 0, 64'h8000_0110, 1, 64'h4};
        vt[5] = '{"all3",     1, 1, 1, 1, 64'hFFFF_0000_1234_5678, 1, 64'h1};
        vt[6] = '{"novalid",  0, 1, 0, 0, 64'h8000_0118, 0, 64'h0};
        vt[7] = '{"noflag",   1, 0, 0, 0, 64'h8000_011C, 0, 64'h0};

        rst = 1'b1;
        ex_valid = 0; ex_ecall = 0; ex_ebreak = 0; ex_mret = 0; ex_pc = '0;
        pipe_empty = 1; mstatus_mie = 0; mie_mtie = 0; mie_msie = 0;
        bus_req = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0;
        b4_req = 0; b4_we = 0; b4_addr = '0; b4_wdata = '0;
        repeat (3) tick();
        chk("rst_ctrl", {58'b0, hold, flush, trap_fire, bus_ack, mtip, msip},
            64'd0);
        chk("rst_vec", csr_vec, 64'd0);
        chk("rst_pc", trap_pc, 64'd0);
        chk("rst_rdata", bus_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        bus_read(A_TIME, ra);
        repeat (4) tick();
        bus_read(A_TIME, rb);
        chk("mtime_delta5", rb - ra, 64'd5);
        bus_read(A_CMP, ra);
        chk("cmp_reset", ra, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_read(16'h1234, ra);
        chk("unmapped_rd", ra, 64'd0);

        for (int i = 0; i < 8; i++) begin
            ex_ecall = vt[i].ecall; ex_ebreak = vt[i].ebreak;
            ex_mret = vt[i].mret;
            ex_valid = vt[i].valid; ex_pc = vt[i].pc; pipe_empty = 1'b1;
            tick();
            chk({vt[i].name, "_hold"}, {63'b0, hold}, {63'b0, vt[i].fire});
            ex_valid = 0; ex_ecall = 0; ex_ebreak = 0; ex_mret = 0;
            tick();
            chk({vt[i].name, "_fire"}, {63'b0, trap_fire}, {63'b0, vt[i].fire});
            chk({vt[i].name, "_vec"}, csr_vec, vt[i].vec);
            chk({vt[i].name, "_pc"}, trap_pc, vt[i].fire ? vt[i].pc : 64'h0);
            tick();
            chk({vt[i].name, "_flush"}, {63'b0, flush}, {63'b0, vt[i].fire});
            tick();
            chk({vt[i].name, "_idle"}, {62'b0, hold, flush}, 64'd0);
        end

        // ecall while older instructions are still in flight
        ex_valid = 1; ex_ecall = 1; ex_pc = 64'h8000_0010; pipe_empty = 0;
        tick();
        ex_valid = 0; ex_ecall = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_hold", {62'b0, hold, trap_fire}, 64'd2);
        end
        pipe_empty = 1;
        tick();
        chk("drain_fire", {63'b0, trap_fire}, 64'd1);
        chk("drain_vec", csr_vec, 64'h4);
        chk("drain_pc", trap_pc, 64'h8000_0010);
        tick();
        chk("drain_flush", {61'b0, hold, flush, trap_fire}, 64'd6);
        tick();
        chk("drain_idle", {62'b0, hold, flush}, 64'd0);

        // Timer interrupt beats a simultaneous ecall
        mstatus_mie = 1; mie_mtie = 1; mie_msie = 1;
        bus_write(A_TIME, 64'd100);
        bus_write(A_CMP, 64'd103);
        chk("mtip_pre", {63'b0, mtip}, 64'd0);
        cnt = 0;
        while (!mtip && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("mtip_rise", cnt, 3);
        ex_ecall = 1;
        run_trap("tmr_int", 64'h8000_0040, 1'b1, V_TIM);
        bus_write(A_MSIP, 64'h3);
        chk("msip_set", {62'b0, mtip, msip}, 64'd3);
        run_trap("tmr_beats_sw", 64'h8000_0044, 1'b1, V_TIM);
        mie_mtie = 0;
        run_trap("sw_int", 64'h8000_0048, 1'b1, V_SW);
        bus_read(A_MSIP, ra);
        chk("msip_rd", ra, 64'd1);

        // Interrupt withdrawn while draining
        ex_valid = 1; ex_pc = 64'h8000_0050; pipe_empty = 1;
        tick();
        ex_valid = 0; pipe_empty = 0; mstatus_mie = 0;
        tick();
        chk("wd_hold", {63'b0, hold}, 64'd1);
        pipe_empty = 1;
        tick();
        chk("wd_nofire", {62'b0, trap_fire, hold}, 64'd1);
        chk("wd_vec", csr_vec, 64'd0);
        tick();
        chk("wd_idle", {62'b0, hold, flush}, 64'd0);
        tick();
        chk("wd_noflush", {62'b0, hold, flush}, 64'd0);
        mie_msie = 0;
        bus_write(A_MSIP, 64'd0);
        bus_write(A_CMP, '1);

        // TICK_DIV=4: wrap through zero
        b4_write(A_TIME, 64'hFFFF_FFFF_FFFF_FFFE);
        repeat (7) tick();
        b4_read(A_TIME, ra);
        chk("wrap_pre", ra, 64'hFFFF_FFFF_FFFF_FFFF);
        b4_read(A_TIME, ra);
        chk("wrap_zero", ra, 64'd0);
        chk("wrap_ack", {63'b0, b4_ack}, 64'd1);

        // Write mid-count restarts the prescaler
        b4_write(A_TIME, 64'd10);
        repeat (2) tick();
        b4_write(A_TIME, 64'd20);
        repeat (3) tick();
        b4_read(A_TIME, ra);
        chk("presc_hold", ra, 64'd20);
        b4_read(A_TIME, ra);
        chk("presc_step", ra, 64'd21);

        // Randomized MMIO traffic against the reference registers
        bus_write(A_TIME, 64'd0);
        bus_write(A_CMP, '1);
        bus_write(A_MSIP, 64'd0);
        m_time = 64'd2; m_cmp = '1; m_msip = 0; m_tip = 0;
        for (int i = 0; i < 300; i++) begin
            logic        rq, we;
            logic [15:0] a;
            logic [63:0] d, exp_rd;
            int          sel;
            rq = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 3);
            a = (sel == 0) ? A_MSIP : (sel == 1) ? A_CMP :
                (sel == 2) ? A_TIME : 16'($urandom);
            if (a == A_CMP)
                d = m_time + 64'($urandom_range(0, 10)) - 64'd5;
            else if (a == A_TIME && $urandom_range(0, 3) != 0)
                d = m_cmp + 64'($urandom_range(0, 10)) - 64'd5;
            else
                d = {$urandom, $urandom};
            bus_req = rq; bus_we = we; bus_addr = a; bus_wdata = d;
            exp_rd = m_read(a);
            tick();
            m_tip = (m_time >= m_cmp);
            if (rq && we && a == A_TIME) m_time = d;
            else                         m_time = m_time + 64'd1;
            if (rq && we && a == A_CMP)  m_cmp = d;
            if (rq && we && a == A_MSIP) m_msip = d[0];
            chk("rnd_ack", {63'b0, bus_ack}, {63'b0, rq});
            if (rq && !we) chk("rnd_rdata", bus_rdata, exp_rd);
            chk("rnd_mtip", {63'b0, mtip}, {63'b0, m_tip});
            chk("rnd_msip", {63'b0, msip}, {63'b0, m_msip});
        end
        bus_req = 0; bus_we = 0;

        // Reset in DRAIN abandons the trap
        ex_valid = 1; ex_ecall = 1; ex_pc = 64'h8000_0060; pipe_empty = 0;
        tick();
        ex_valid = 0; ex_ecall = 0;
        chk("rstd_hold", {63'b0, hold}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstd_async", {61'b0, hold, flush, trap_fire}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pipe_empty = 1;
        tick();
        tick();
        chk("rstd_nofire", {61'b0, hold, flush, trap_fire}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
